// File: rtl/ram_lsu_if.sv
// Request, response and RAM-side signals of the load/store unit.
// The slave modport is the LSU's view; master is the CPU/RAM environment.
interface ram_lsu_if #(parameter int W = 32);
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [1:0]   req_size;
    logic         req_unsigned;
    logic [W-1:0] req_addr;
    logic [W-1:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_rdata;
    logic         rsp_error;
    logic         mem_write_en;
    logic [W-1:0] mem_addr_write;
    logic [W-1:0] mem_data_write;
    logic [W-1:0] mem_addr_read;
    logic [W-1:0] mem_data_read;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_data_read,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_write_en, mem_addr_write, mem_data_write, mem_addr_read
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_data_read,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_write_en, mem_addr_write, mem_data_write, mem_addr_read
    );
endinterface

// File: rtl/ram_lsu.sv
// Byte-addressed load/store unit in front of a word-wide RAM without byte enables.
// Sub-word stores are done as read-modify-write; one transaction in flight.
//  state     | meaning
//  IDLE      | ready for a request
//  LD_ISSUE  | drive read address for a load
//  LD_CAPT   | read data valid, extend and register it
//  RMW_ISSUE | drive read address for a sub-word store
//  RMW_MERGE | read data valid, merge store lane into it
//  ST_WRITE  | write word (read address held at idx so RAM commits)
//  RESP      | hold response until rsp_ready
module ram_lsu #(
    parameter int BUS_WIDTH = 32,
    parameter int ADDR_BASE = 0,
    parameter int MEM_SIZE  = 256
) (
    input  logic       clk,
    input  logic       reset,
    ram_lsu_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LD_ISSUE, S_LD_CAPT, S_RMW_ISSUE, S_RMW_MERGE, S_ST_WRITE, S_RESP
    } state_t;

    localparam logic [BUS_WIDTH-1:0] BASE      = BUS_WIDTH'(ADDR_BASE);
    localparam logic [BUS_WIDTH-1:0] MEM_WORDS = BUS_WIDTH'(MEM_SIZE);

    state_t               state, state_nxt;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic [1:0]           r_off;
    logic [BUS_WIDTH-1:0] r_idx;
    logic [BUS_WIDTH-1:0] r_wdata;
    logic [BUS_WIDTH-1:0] merge_q;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic                 error_q;

    logic                 accept;
    logic                 req_err;
    logic [BUS_WIDTH-1:0] req_idx;
    logic [BUS_WIDTH-1:0] merged;
    logic [BUS_WIDTH-1:0] lane;
    logic [BUS_WIDTH-1:0] load_ext;

    assign accept  = (state == S_IDLE) && bus.req_valid;
    assign req_idx = (bus.req_addr - BASE) >> 2;
    assign req_err = (bus.req_size == 2'b11)
                   || (bus.req_size == 2'b01 && bus.req_addr[0])
                   || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                   || (req_idx >= MEM_WORDS);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)                   state_nxt = S_RESP;
                    else if (!bus.req_write)       state_nxt = S_LD_ISSUE;
                    else if (bus.req_size == 2'b10) state_nxt = S_ST_WRITE;
                    else                           state_nxt = S_RMW_ISSUE;
                end
            end
            S_LD_ISSUE:  state_nxt = S_LD_CAPT;
            S_LD_CAPT:   state_nxt = S_RESP;
            S_RMW_ISSUE: state_nxt = S_RMW_MERGE;
            S_RMW_MERGE: state_nxt = S_ST_WRITE;
            S_ST_WRITE:  state_nxt = S_RESP;
            S_RESP:      if (bus.rsp_ready) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        merged = bus.mem_data_read;
        if (r_size == 2'b00) begin
            case (r_off)
                2'd0: merged[7:0]   = r_wdata[7:0];
                2'd1: merged[15:8]  = r_wdata[7:0];
                2'd2: merged[23:16] = r_wdata[7:0];
                default: merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_off[1]) begin
            merged[31:16] = r_wdata[15:0];
        end else begin
            merged[15:0] = r_wdata[15:0];
        end
    end

    always_comb begin
        lane = bus.mem_data_read >> {r_off, 3'b000};
        case (r_size)
            2'b00:   load_ext = {{24{~r_unsigned & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{16{~r_unsigned & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Request fields latch only on accept, so idle X on the bus never enters the datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_off      <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            if (accept) begin
                r_size     <= bus.req_size;
                r_unsigned <= bus.req_unsigned;
                r_off      <= bus.req_addr[1:0];
                r_idx      <= req_idx;
                r_wdata    <= bus.req_wdata;
                rdata_q    <= '0;
                error_q    <= req_err;
            end
            if (state == S_RMW_MERGE) merge_q <= merged;
            if (state == S_LD_CAPT)   rdata_q <= load_ext;
        end
    end

    always_comb begin
        bus.req_ready      = (state == S_IDLE);
        bus.rsp_valid      = (state == S_RESP);
        bus.rsp_rdata      = rdata_q;
        bus.rsp_error      = error_q;
        bus.mem_write_en   = 1'b0;
        bus.mem_addr_write = '0;
        bus.mem_data_write = '0;
        bus.mem_addr_read  = '0;
        case (state)
            S_LD_ISSUE, S_RMW_ISSUE: bus.mem_addr_read = r_idx;
            S_ST_WRITE: begin
                bus.mem_addr_read  = r_idx;
                bus.mem_write_en   = 1'b1;
                bus.mem_addr_write = r_idx;
                bus.mem_data_write = (r_size == 2'b10) ? r_wdata : merge_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ram_lsu.sv
// Directed bench for ram_lsu with a behavioural 256-word RAM (registered read,
// write committed only when the read address is in range).
module tb_ram_lsu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   wr_pulses = 0;
    logic [31:0] last_wr_idx = '0;
    logic [31:0] ram [0:255];

    ram_lsu_if #(.W(32)) bus ();

    ram_lsu #(.BUS_WIDTH(32), .ADDR_BASE(0), .MEM_SIZE(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_write_en && bus.mem_addr_read < 32'd256 && bus.mem_addr_write < 32'd256)
            ram[bus.mem_addr_write[7:0]] <= bus.mem_data_write;
        bus.mem_data_read <= (bus.mem_addr_read < 32'd256) ? ram[bus.mem_addr_read[7:0]] : 32'h0;
    end

    always @(negedge clk) begin
        if (bus.mem_write_en) begin
            wr_pulses   <= wr_pulses + 1;
            last_wr_idx <= bus.mem_addr_write;
        end
    end

    // Full transaction: returns latency from accept edge to rsp_valid (-1 on timeout).
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
        int n;
        lat = -1; rd = '0; er = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.req_ready) return;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_addr = 'x; bus.req_wdata = 'x;
        bus.req_size = 'x; bus.req_write = 'x; bus.req_unsigned = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = c; rd = bus.rsp_rdata; er = bus.rsp_error;
                break;
            end
        end
        if (lat < 0) return;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs got ready=%b valid=%b err=%b exp 1 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_error);
        end
        checks++;
        if (bus.rsp_rdata !== 32'h0 || bus.mem_write_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h we=%b exp 0 0", bus.rsp_rdata, bus.mem_write_en);
        end
        checks++;
        if ({bus.mem_addr_read, bus.mem_addr_write, bus.mem_data_write} !== 96'h0) begin
            failures++;
            $display("FAIL reset_mem got ra=%h wa=%h wd=%h exp 0", bus.mem_addr_read,
                     bus.mem_addr_write, bus.mem_data_write);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er; int p0;
        p0 = wr_pulses;
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd, er);
        checks++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL word_store got lat=%0d err=%b rd=%h exp 2 0 0", lat, er, rd);
        end
        checks++;
        if (wr_pulses != p0 + 1 || last_wr_idx !== 32'h40 || ram[8'h40] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_write got pulses=%0d idx=%h ram=%h exp %0d 40 deadbeef",
                     wr_pulses - p0, last_wr_idx, ram[8'h40], 1);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er);
        checks++;
        if (lat != 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_load got lat=%0d err=%b rd=%h exp 3 0 deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_byte();
        int lat; logic [31:0] rd; logic er;
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, lat, rd, er);
        issue(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFFFFA5, lat, rd, er);
        checks++;
        if (lat != 4 || er !== 1'b0 || ram[8'h40] !== 32'h1122A544) begin
            failures++;
            $display("FAIL byte_store got lat=%0d err=%b ram=%h exp 4 0 1122a544", lat, er, ram[8'h40]);
        end
        issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, lat, rd, er);
        checks++;
        if (lat != 3 || rd !== 32'hFFFFFFA5) begin
            failures++;
            $display("FAIL byte_load_s got lat=%0d rd=%h exp 3 ffffffa5", lat, rd);
        end
        issue(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h000000A5) begin
            failures++;
            $display("FAIL byte_load_u got rd=%h exp 000000a5", rd);
        end
        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h00000011) begin
            failures++;
            $display("FAIL byte_load_top got rd=%h exp 00000011", rd);
        end
    endtask

    task automatic test_half();
        int lat; logic [31:0] rd; logic er;
        issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h12348001, lat, rd, er);
        checks++;
        if (lat != 4 || er !== 1'b0 || ram[8'h40] !== 32'h8001A544) begin
            failures++;
            $display("FAIL half_store got lat=%0d err=%b ram=%h exp 4 0 8001a544", lat, er, ram[8'h40]);
        end
        issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hFFFF8001) begin
            failures++;
            $display("FAIL half_load_s got rd=%h exp ffff8001", rd);
        end
        issue(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hFFFFA544) begin
            failures++;
            $display("FAIL half_load_lo got rd=%h exp ffffa544", rd);
        end
        issue(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0000A544) begin
            failures++;
            $display("FAIL half_load_u got rd=%h exp 0000a544", rd);
        end
    endtask

    task automatic test_errors();
        logic        e_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0]  e_sz   [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] e_addr [4] = '{32'h103, 32'h102, 32'h100, 32'h400};
        int lat; logic [31:0] rd; logic er; int p0;
        for (int i = 0; i < 4; i++) begin
            p0 = wr_pulses;
            issue(e_wr[i], e_sz[i], 1'b0, e_addr[i], 32'h55AA55AA, lat, rd, er);
            checks++;
            if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || wr_pulses != p0) begin
                failures++;
                $display("FAIL err_case%0d got lat=%0d err=%b rd=%h writes=%0d exp 1 1 0 0",
                         i, lat, er, rd, wr_pulses - p0);
            end
        end
        checks++;
        if (ram[8'h40] !== 32'h8001A544 || ram[8'h00] !== 32'h0) begin
            failures++;
            $display("FAIL err_ram got ram40=%h ram0=%h exp 8001a544 0", ram[8'h40], ram[8'h00]);
        end
    endtask

    task automatic test_backpressure();
        int seen = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h100; bus.req_wdata = 32'h0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL bp_timeout got no rsp_valid exp rsp_valid within 20 cycles");
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h8001A544 || bus.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got valid=%b rd=%h ready=%b exp 1 8001a544 0",
                         c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got ready=%b valid=%b exp 1 0", bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_reset_rmw();
        int p0;
        p0 = wr_pulses;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h100; bus.req_wdata = 32'h77;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_write_en !== 1'b0 ||
            bus.mem_addr_read !== 32'h0 || bus.mem_data_write !== 32'h0) begin
            failures++;
            $display("FAIL rmw_reset_out got ready=%b valid=%b we=%b ra=%h wd=%h exp 1 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.mem_write_en, bus.mem_addr_read, bus.mem_data_write);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ram[8'h40] !== 32'h8001A544 || wr_pulses != p0) begin
            failures++;
            $display("FAIL rmw_reset_ram got ram=%h writes=%0d exp 8001a544 0", ram[8'h40], wr_pulses - p0);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er;
        issue(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, lat, rd, er);
        issue(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, lat, rd, er);
        checks++;
        if (lat != 3 || er !== 1'b0 || rd !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL b2b_top got lat=%0d err=%b rd=%h exp 3 0 cafef00d", lat, er, rd);
        end
        issue(1'b1, 2'b00, 1'b0, 32'h3FF, 32'h000000EE, lat, rd, er);
        issue(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hEEFEF00D || ram[8'hFF] !== 32'hEEFEF00D) begin
            failures++;
            $display("FAIL b2b_byte3 got rd=%h ram=%h exp eefef00d", rd, ram[8'hFF]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0; bus.mem_data_read = '0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_rmw();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got time limit exp bench to finish");
        $fatal(1, "watchdog");
    end
endmodule
